kbonacci: RTL
=============

KBONACCI -- requirements
Module: kbonacci

Interface
REQ-001 Parameter BITS, default 32: word width of index, seeds and terms.
REQ-002 Parameter ORDER, default 2: recurrence order k; legal range 2..4; each term is the sum of the previous k terms.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 INP  in  BITS  requested term index n, sampled with IE.
REQ-006 IE  in  1  request strobe; accepted only while READY=1.
REQ-007 SEED_WE  in  1  seed write strobe; honoured only while READY=1.
REQ-008 SEED_SEL  in  2  seed slot 0..ORDER-1; values >= ORDER ignored.
REQ-009 SEED  in  BITS  seed write data.
REQ-010 STREAM  in  1  mode: 1 = present every computed term, 0 = present final term only; sampled with IE.
REQ-011 ACK  in  1  consumer accepts the presented OUT.
REQ-012 OUT  out  BITS  presented term.
REQ-013 OE  out  1  OUT valid; held with OUT stable until ACK.
REQ-014 LAST  out  1  qualifies OE: presented term is t(n).
REQ-015 OVF  out  1  a wrap occurred in any term computed so far for this request.
REQ-016 READY  out  1  idle; new request or seed write may be accepted.

Function
REQ-017 Terms t(0..k-1) are the seed slots; t(i) = sum t(i-k..i-1) modulo 2^BITS for i >= k.
REQ-018 FSM states: IDLE, RUN, HOLD (stream wait), DONE; READY=1 only in IDLE.
REQ-019 IDLE + IE: capture n, STREAM; load window with seeds; clear OVF; n < k -> DONE with OUT=seed[n], LAST=1; else -> RUN.
REQ-020 RUN: one term per edge; window shifts and appends the sum; step counter decrements from n-k+1.
REQ-021 Final step (t(n)) -> DONE with OUT=t(n), LAST=1; with IE on edge 1, OE is high after edge n-k+2 (STREAM=0, no stalls).
REQ-022 STREAM=1: each non-final term goes to HOLD with OE=1, LAST=0; ACK returns to RUN and the next term follows on the next edge; OE drops for at least one cycle between terms.
REQ-023 DONE: OE=1 until an edge with ACK=1 -> IDLE, OE=0, LAST=0.
REQ-024 ACK without OE is ignored; IE or SEED_WE while READY=0 is ignored with no side effects.
REQ-025 OVF sets when any term computed in RUN (any k-input sum) exceeds 2^BITS-1; sticky until the next accepted IE; seeds never set OVF.
REQ-026 SEED_WE in IDLE writes slot SEED_SEL on that edge; IE and SEED_WE together: the write happens first and the request uses the new seed.
REQ-027 n = 0 returns t(0); the maximum n = 2^BITS-1 is legal with no counter wrap.

Reset
REQ-028 RST_N low, at any time including mid-run: state IDLE, OUT=0, OE=0, LAST=0, OVF=0, READY=1 (from the asynchronous assertion on).
REQ-029 Reset seeds: slots 0..k-2 = 0, slot k-1 = 1 (classic k-bonacci); pending request discarded.
REQ-030 Deassertion is synchronised by the integration level; the block needs no internal synchroniser.

Structure
REQ-031 Package kbonacci_pkg holds the state enum, MAX_ORDER=4 and the default-seed function.
REQ-032 Sub-module kb_window: ORDER-deep shift register plus (BITS+2)-bit adder tree, with the carry above BITS giving OVF.
REQ-033 Elaboration error if ORDER is outside 2..4.

Verification
REQ-034 BITS=32, k=2, reset seeds, n=10, STREAM=0 -> OUT=55, LAST=1, OE after edge 10; n=0 -> 0, n=1 -> 1 after edge 1.
REQ-035 k=3, reset seeds, n=7 -> OUT=13; STREAM=1 -> 1,2,4,7 (LAST=0) then 13 (LAST=1), each held under an ACK delay of 3 cycles.
REQ-036 k=2, seeds written 2,1 (Lucas), n=5 -> OUT=11; IE with SEED_WE slot0=3 -> result uses 3.
REQ-037 BITS=8, k=2: n=13 -> 233, OVF=0; n=14 -> 121, OVF=1; the next request clears OVF.
REQ-038 RST_N pulsed mid-RUN at n=20 -> OE=0, READY=1 immediately; seeds default; a new request n=10 -> 55.
REQ-039 IE and SEED_WE while busy, and ACK while OE=0 -> no effect on the result or the seeds.

Source files
------------

// File: rtl/kbonacci_pkg.sv
// Shared types and helpers for the k-bonacci term generator.
package kbonacci_pkg;

  localparam int MAX_ORDER = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } kb_state_e;

  // Classic k-bonacci seeding: every slot zero except the last, which is one.
  function automatic logic default_seed_lsb(input int slot, input int order);
    return (slot == order - 1);
  endfunction

endpackage

// File: rtl/kbonacci_window.sv
// Sliding window of the last ORDER terms plus the adder that forms the next term.
module kb_window
  import kbonacci_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int ORDER = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       shift,
  input  logic [ORDER-1:0][BITS-1:0] load_data,
  output logic [BITS-1:0]            term,
  output logic                       carry
);

  logic [ORDER-1:0][BITS-1:0] win;
  logic [BITS+1:0]            sum;

  // Two guard bits hold the full sum of up to four words, so any wrap shows up as carry.
  always_comb begin
    sum = '0;
    for (int j = 0; j < ORDER; j++) begin
      sum = sum + {2'b00, win[j]};
    end
  end

  assign term  = sum[BITS-1:0];
  assign carry = |sum[BITS+1:BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (load) begin
      win <= load_data;
    end else if (shift) begin
      for (int j = 0; j < ORDER - 1; j++) begin
        win[j] <= win[j+1];
      end
      win[ORDER-1] <= term;
    end
  end

endmodule

// File: rtl/kbonacci.sv
// k-bonacci term generator: returns t(n), optionally streaming every computed term.
module kbonacci
  import kbonacci_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int ORDER = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] inp,
  input  logic            ie,
  input  logic            seed_we,
  input  logic [1:0]      seed_sel,
  input  logic [BITS-1:0] seed,
  input  logic            stream,
  input  logic            ack,
  output logic [BITS-1:0] out,
  output logic            oe,
  output logic            last,
  output logic            ovf,
  output logic            ready
);

  if (ORDER < 2 || ORDER > MAX_ORDER) begin : g_order_check
    $error("kbonacci: ORDER must be in 2..4");
  end

  kb_state_e                  state;
  logic [BITS-1:0]            cnt;
  logic                       stream_q;
  logic [ORDER-1:0][BITS-1:0] seeds;
  logic [ORDER-1:0][BITS-1:0] load_data;
  logic [BITS-1:0]            small_val;
  logic                       n_small;
  logic [BITS-1:0]            term;
  logic                       carry;
  logic                       accept;

  assign ready   = (state == IDLE);
  assign accept  = ready && ie;
  assign n_small = (inp < BITS'(ORDER));

  // A write in the same cycle as a request is merged here so the request sees the new seed.
  always_comb begin
    load_data = seeds;
    if (seed_we) begin
      for (int j = 0; j < ORDER; j++) begin
        if (seed_sel == 2'(j)) load_data[j] = seed;
      end
    end
  end

  always_comb begin
    small_val = '0;
    for (int j = 0; j < ORDER; j++) begin
      if (inp == BITS'(j)) small_val = load_data[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < ORDER; j++) begin
        seeds[j] <= {{(BITS-1){1'b0}}, default_seed_lsb(j, ORDER)};
      end
    end else if (ready && seed_we) begin
      seeds <= load_data;
    end
  end

  kb_window #(
    .BITS  (BITS),
    .ORDER (ORDER)
  ) u_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (state == RUN),
    .load_data (load_data),
    .term      (term),
    .carry     (carry)
  );

  // cnt holds the number of terms still to compute; it starts at n-k+1 so n = 2^BITS-1 fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out      <= '0;
      oe       <= 1'b0;
      last     <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
      stream_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ie) begin
            stream_q <= stream;
            ovf      <= 1'b0;
            if (n_small) begin
              out   <= small_val;
              oe    <= 1'b1;
              last  <= 1'b1;
              state <= DONE;
            end else begin
              cnt   <= inp - BITS'(ORDER - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (carry) ovf <= 1'b1;
          if (cnt == BITS'(1)) begin
            out   <= term;
            oe    <= 1'b1;
            last  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - BITS'(1);
            if (stream_q) begin
              out   <= term;
              oe    <= 1'b1;
              last  <= 1'b0;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ack) begin
            oe    <= 1'b0;
            state <= RUN;
          end
        end
        DONE: begin
          if (ack) begin
            oe    <= 1'b0;
            last  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
